// File: rtl/axis_sha3_block_packer.sv
// AXI-Stream front end for the SHA3/Keccak core. It packs byte-qualified words into rate-sized
// blocks and applies FIPS 202 padding on TLAST. Define SHA3_SHAKE_EN to enable the SHAKE128/256 modes.
module axis_sha3_block_packer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [WIDTH-1:0]   S_TDATA,
  input  logic [WIDTH/8-1:0] S_TKEEP,
  input  logic               S_TVALID,
  input  logic               S_TLAST,
  input  logic [2:0]         S_TUSER,
  output logic               S_TREADY,
  output logic [1599:0]      BLK_DATA,
  output logic [2:0]         BLK_MODE,
  output logic               BLK_FIRST,
  output logic               BLK_LAST,
  output logic               BLK_VALID,
  input  logic               BLK_READY
);
  localparam int unsigned BPW    = WIDTH / 8;
  localparam int unsigned BPW_SH = $clog2(BPW);
  localparam int unsigned BLK_W  = 1600;
  localparam int unsigned IDX_W  = 11;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {ST_FILL, ST_HOLD, ST_PAD} state_t;

  state_t             r_state, w_next_state;
  logic [BLK_W-1:0]   r_buf, w_buf;
  logic [CNT_W-1:0]   r_wc, w_wc;
  logic [2:0]         r_mode, w_mode;
  logic               r_in_msg, w_in_msg;
  logic               r_pad_pending, w_pad_pending;
  logic               r_next_first, w_next_first;
  logic               r_blk_first, w_first;
  logic               r_blk_last, w_last;
  logic               r_blk_valid;
  logic               r_tready;

  logic [2:0]         w_tuser_mode, w_cur_mode;
  logic [CNT_W-1:0]   w_rb_cur, w_rb_cur_m1, w_rb_held_m1, w_words_m1;
  logic [CNT_W-1:0]   w_keep_cnt, w_p;
  logic [IDX_W-1:0]   w_word_base;
  logic [WIDTH-1:0]   w_word;
  logic [7:0]         w_dom_cur, w_dom_held;

  // Rate in bytes for a (masked) mode; bit 2 is only ever set when SHAKE is enabled.
  function automatic logic [CNT_W-1:0] rate_bytes(input logic [2:0] mode);
    logic [CNT_W-1:0] rb;
    case (mode[1:0])
      2'd0:    rb = 8'd144;
      2'd1:    rb = 8'd136;
      2'd2:    rb = 8'd104;
      default: rb = 8'd72;
    endcase
    if (mode[2]) rb = mode[0] ? 8'd136 : 8'd168;
    return rb;
  endfunction

`ifdef SHA3_SHAKE_EN
  assign w_tuser_mode = S_TUSER;
`else
  assign w_tuser_mode = S_TUSER & 3'b011;
`endif

  // Mode is taken from TUSER only on the first word of a message.
  assign w_cur_mode   = r_in_msg ? r_mode : w_tuser_mode;
  assign w_rb_cur     = rate_bytes(w_cur_mode);
  assign w_rb_cur_m1  = w_rb_cur - CNT_W'(1);
  assign w_rb_held_m1 = rate_bytes(r_mode) - CNT_W'(1);
  assign w_words_m1   = CNT_W'(w_rb_cur >> BPW_SH) - CNT_W'(1);
  assign w_keep_cnt   = CNT_W'($countones(S_TKEEP));
  assign w_p          = CNT_W'(r_wc << BPW_SH) + w_keep_cnt;
  assign w_word_base  = IDX_W'(r_wc) * IDX_W'(WIDTH);
  assign w_dom_cur    = w_cur_mode[2] ? 8'h1F : 8'h06;
  assign w_dom_held   = r_mode[2] ? 8'h1F : 8'h06;

  // Next-state, buffer update and block flags.
  always_comb begin
    w_next_state  = r_state;
    w_buf         = r_buf;
    w_wc          = r_wc;
    w_mode        = r_mode;
    w_in_msg      = r_in_msg;
    w_pad_pending = r_pad_pending;
    w_next_first  = r_next_first;
    w_first       = r_blk_first;
    w_last        = r_blk_last;
    w_word        = '0;
    for (int j = 0; j < int'(BPW); j++) begin
      if (!S_TLAST || S_TKEEP[j]) w_word[8*j +: 8] = S_TDATA[8*j +: 8];
    end
    case (r_state)
      ST_FILL: begin
        if (S_TVALID && r_tready) begin
          w_mode   = w_cur_mode;
          w_in_msg = !S_TLAST;
          w_buf[w_word_base +: WIDTH] = w_word;
          w_wc     = r_wc + CNT_W'(1);
          w_first  = r_next_first;
          if (S_TLAST) begin
            w_next_state = ST_HOLD;
            if (w_p < w_rb_cur) begin
              w_buf[{w_p, 3'b000} +: 8]         = w_buf[{w_p, 3'b000} +: 8] ^ w_dom_cur;
              w_buf[{w_rb_cur_m1, 3'b000} +: 8] = w_buf[{w_rb_cur_m1, 3'b000} +: 8] ^ 8'h80;
              w_last        = 1'b1;
              w_pad_pending = 1'b0;
            end else begin
              w_last        = 1'b0;
              w_pad_pending = 1'b1;
            end
          end else if (r_wc == w_words_m1) begin
            w_next_state = ST_HOLD;
            w_last       = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (BLK_READY) begin
          w_buf        = '0;
          w_wc         = '0;
          w_next_first = r_blk_last;
          w_next_state = r_pad_pending ? ST_PAD : ST_FILL;
        end
      end
      ST_PAD: begin
        w_buf                              = '0;
        w_buf[7:0]                         = w_dom_held;
        w_buf[{w_rb_held_m1, 3'b000} +: 8] = 8'h80;
        w_first                            = 1'b0;
        w_last                             = 1'b1;
        w_pad_pending                      = 1'b0;
        w_next_state                       = ST_HOLD;
      end
      default: w_next_state = ST_FILL;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state       <= ST_FILL;
      r_buf         <= '0;
      r_wc          <= '0;
      r_mode        <= '0;
      r_in_msg      <= 1'b0;
      r_pad_pending <= 1'b0;
      r_next_first  <= 1'b1;
      r_blk_first   <= 1'b0;
      r_blk_last    <= 1'b0;
      r_blk_valid   <= 1'b0;
      r_tready      <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_buf         <= w_buf;
      r_wc          <= w_wc;
      r_mode        <= w_mode;
      r_in_msg      <= w_in_msg;
      r_pad_pending <= w_pad_pending;
      r_next_first  <= w_next_first;
      r_blk_first   <= w_first;
      r_blk_last    <= w_last;
      r_blk_valid   <= (w_next_state == ST_HOLD);
      r_tready      <= (w_next_state == ST_FILL);
    end
  end

  assign S_TREADY  = r_tready;
  assign BLK_DATA  = r_buf;
  assign BLK_MODE  = r_mode;
  assign BLK_FIRST = r_blk_first;
  assign BLK_LAST  = r_blk_last;
  assign BLK_VALID = r_blk_valid;

endmodule
